// File: rtl/term_writer_pkg.sv
// Shared character codes, FSM state type and row-wrap helpers for the terminal writer.
package term_writer_pkg;

  localparam logic YES  = 1'b1;
  localparam logic NO   = 1'b0;
  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam logic [7:0] ChBs    = 8'h08;
  localparam logic [7:0] ChLf    = 8'h0A;
  localparam logic [7:0] ChFf    = 8'h0C;
  localparam logic [7:0] ChCr    = 8'h0D;
  localparam logic [7:0] ChSpace = 8'h20;
  localparam logic [7:0] ChTilde = 8'h7E;

  typedef enum logic [1:0] {
    StIdle,
    StScroll,
    StClearAll
  } state_e;

  // (top + r) mod rows without depending on 5-bit wraparound; both inputs are < rows.
  function automatic logic [4:0] phys_row(input logic [4:0] top, input logic [4:0] r,
                                          input logic [5:0] rows);
    logic [5:0] sum;
    sum = {1'b0, top} + {1'b0, r};
    if (sum >= rows) sum = sum - rows;
    return sum[4:0];
  endfunction

  function automatic logic is_printable(input logic [7:0] ch);
    return (ch >= ChSpace) && (ch <= ChTilde);
  endfunction

endpackage

// File: rtl/term_writer.sv
// Character stream to text vram writer with cursor control, ring-buffer scrolling and
// full-screen clear; one shared row/column counter drives both bulk-fill states.
module term_writer
  import term_writer_pkg::*;
#(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_char,
  output logic       in_ready,
  output logic       write_ce,
  output logic [4:0] write_row,
  output logic [6:0] write_col,
  output logic [7:0] write_char,
  output logic [4:0] top_row,
  output logic [4:0] cursor_row,
  output logic [6:0] cursor_col
);

  localparam logic [5:0] RowsW   = 6'(ROWS);
  localparam logic [7:0] ColsW   = 8'(COLS);
  localparam logic [4:0] LastRow = 5'(ROWS - 1);
  localparam logic [6:0] LastCol = 7'(COLS - 1);

  state_e     state;
  logic [4:0] cnt_row;
  logic [6:0] cnt_col;

  logic       accept;
  logic       printable;
  logic [7:0] col_inc;
  logic       newline;

  always_comb begin
    accept    = (state == StIdle) && in_valid && in_ready;
    printable = is_printable(in_char);
    col_inc   = {1'b0, cursor_col} + 8'd1;
    newline   = accept && ((printable && (col_inc >= ColsW)) || (in_char == ChLf));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StClearAll;
      in_ready   <= LOW;
      write_ce   <= LOW;
      write_row  <= '0;
      write_col  <= '0;
      write_char <= '0;
      top_row    <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      cnt_row    <= '0;
      cnt_col    <= '0;
    end else begin
      write_ce <= LOW;
      in_ready <= LOW;
      unique case (state)
        StIdle: begin
          in_ready <= HIGH;
          if (accept) begin
            if (printable) begin
              write_ce   <= HIGH;
              write_row  <= phys_row(top_row, cursor_row, RowsW);
              write_col  <= cursor_col;
              write_char <= in_char;
              cursor_col <= (col_inc < ColsW) ? col_inc[6:0] : 7'd0;
            end else begin
              case (in_char)
                ChCr: cursor_col <= 7'd0;
                ChBs: if (cursor_col != 7'd0) cursor_col <= cursor_col - 7'd1;
                ChFf: begin
                  cursor_row <= 5'd0;
                  cursor_col <= 7'd0;
                  top_row    <= 5'd0;
                  cnt_row    <= 5'd0;
                  cnt_col    <= 7'd0;
                  in_ready   <= LOW;
                  state      <= StClearAll;
                end
                default: ;
              endcase
            end
            if (newline) begin
              if (cursor_row < LastRow) begin
                cursor_row <= cursor_row + 5'd1;
              end else begin
                cnt_col  <= 7'd0;
                in_ready <= LOW;
                state    <= StScroll;
              end
            end
          end
        end
        StScroll: begin
          // The row about to become the bottom line is blanked before top_row advances.
          write_ce   <= HIGH;
          write_row  <= top_row;
          write_col  <= cnt_col;
          write_char <= ChSpace;
          if (cnt_col == LastCol) begin
            cnt_col <= 7'd0;
            top_row <= (top_row == LastRow) ? 5'd0 : top_row + 5'd1;
            state   <= StIdle;
          end else begin
            cnt_col <= cnt_col + 7'd1;
          end
        end
        StClearAll: begin
          write_ce   <= HIGH;
          write_row  <= cnt_row;
          write_col  <= cnt_col;
          write_char <= ChSpace;
          if (cnt_col == LastCol) begin
            cnt_col <= 7'd0;
            if (cnt_row == LastRow) begin
              cnt_row <= 5'd0;
              state   <= StIdle;
            end else begin
              cnt_row <= cnt_row + 5'd1;
            end
          end else begin
            cnt_col <= cnt_col + 7'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_term_writer.sv
// Bench for term_writer: expected vram writes and cursor state come from a screen-level model.
module tb_term_writer;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic       in_ready;
  logic       write_ce;
  logic [4:0] write_row;
  logic [6:0] write_col;
  logic [7:0] write_char;
  logic [4:0] top_row;
  logic [4:0] cursor_row;
  logic [6:0] cursor_col;

  term_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_ready  (in_ready),
    .write_ce  (write_ce),
    .write_row (write_row),
    .write_col (write_col),
    .write_char(write_char),
    .top_row   (top_row),
    .cursor_row(cursor_row),
    .cursor_col(cursor_col)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int row; int col; int ch; bit bulk;} exp_t;
  typedef struct {int row; int col; int ch; logic rdy; int cyc;} got_t;
  exp_t exp_q[$];
  got_t got_q[$];

  always @(negedge clk) begin
    got_t g;
    if (write_ce === 1'b1) begin
      g.row = int'(write_row);
      g.col = int'(write_col);
      g.ch  = int'(write_char);
      g.rdy = in_ready;
      g.cyc = cyc;
      got_q.push_back(g);
    end
  end

  // Screen model: logical cursor, ring top and the list of writes the rules imply.
  int m_row, m_col, m_top;

  function automatic void push_exp(input int r, input int c, input int ch, input bit b);
    exp_t e;
    e.row = r; e.col = c; e.ch = ch; e.bulk = b;
    exp_q.push_back(e);
  endfunction

  function automatic void model_newline();
    if (m_row < ROWS - 1) m_row++;
    else begin
      for (int c = 0; c < COLS; c++) push_exp(m_top, c, 32, 1'b1);
      m_top = (m_top + 1) % ROWS;
    end
  endfunction

  function automatic void model_clear();
    m_row = 0; m_col = 0; m_top = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) push_exp(r, c, 32, 1'b1);
  endfunction

  function automatic void model_accept(input int ch);
    if (ch >= 32 && ch <= 126) begin
      push_exp((m_top + m_row) % ROWS, m_col, ch, 1'b0);
      if (m_col + 1 < COLS) m_col++;
      else begin
        m_col = 0;
        model_newline();
      end
    end else if (ch == 13) m_col = 0;
    else if (ch == 8) begin
      if (m_col > 0) m_col--;
    end else if (ch == 10) model_newline();
    else if (ch == 12) model_clear();
  endfunction

  task automatic send(input logic [7:0] c);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = c;
    n = 0;
    while (in_ready !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_handshake: in_ready=%b required 1 for char %h", in_ready, c);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      model_accept(int'(c));
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    @(negedge clk);
    #1;
    n = 0;
    while (in_ready !== 1'b1 && n < 6000) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s idle_timeout: in_ready=%b required 1", tag, in_ready);
    end
  endtask

  task automatic scoreboard_drain(input string tag);
    int n;
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s write_count: got %0d required %0d", tag, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (got_q[i].row !== exp_q[i].row || got_q[i].col !== exp_q[i].col ||
          got_q[i].ch !== exp_q[i].ch || (exp_q[i].bulk && got_q[i].rdy !== 1'b0)) begin
        bad++;
        $display("FAIL %s write[%0d]: got (%0d,%0d,%h,rdy=%b) required (%0d,%0d,%h%s)", tag, i,
                 got_q[i].row, got_q[i].col, got_q[i].ch, got_q[i].rdy, exp_q[i].row,
                 exp_q[i].col, exp_q[i].ch, exp_q[i].bulk ? ",rdy=0" : "");
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic home_screen(input string tag);
    send(8'h0C);
    wait_idle(tag);
    scoreboard_drain(tag);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (write_ce !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_strobes: write_ce=%b in_ready=%b required 0 0", write_ce, in_ready);
    end
    total++;
    if (top_row !== 5'd0 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
      bad++;
      $display("FAIL reset_position: top=%0d cursor=(%0d,%0d) required 0 (0,0)", top_row,
               cursor_row, cursor_col);
    end
    got_q.delete();
    exp_q.delete();
    model_clear();
    reset = 1'b0;
    wait_idle("reset_clear");
    total++;
    if (got_q.size() != ROWS * COLS ||
        got_q[got_q.size() - 1].cyc - got_q[0].cyc != ROWS * COLS - 1) begin
      bad++;
      $display("FAIL reset_clear_contiguous: %0d writes not on %0d consecutive cycles",
               got_q.size(), ROWS * COLS);
    end
    scoreboard_drain("reset_clear");
    total++;
    if (in_ready !== 1'b1 || top_row !== 5'd0 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
      bad++;
      $display("FAIL reset_after_clear: rdy=%b top=%0d cursor=(%0d,%0d) required 1 0 (0,0)",
               in_ready, top_row, cursor_row, cursor_col);
    end
  endtask

  task automatic test_back_to_back();
    send("A");
    send("B");
    wait_idle("back_to_back");
    total++;
    if (got_q.size() < 2 || got_q[1].cyc != got_q[0].cyc + 1) begin
      bad++;
      $display("FAIL back_to_back_timing: %0d writes, not on consecutive cycles", got_q.size());
    end
    scoreboard_drain("back_to_back");
    total++;
    if (cursor_col !== 7'd2) begin
      bad++;
      $display("FAIL back_to_back_col: got %0d required 2", cursor_col);
    end
  endtask

  task automatic test_line_wrap();
    home_screen("wrap_home");
    for (int i = 0; i < COLS; i++) send("x");
    wait_idle("wrap");
    total++;
    if (got_q.size() != COLS || got_q[got_q.size() - 1].row != 0 ||
        got_q[got_q.size() - 1].col != COLS - 1) begin
      bad++;
      $display("FAIL wrap_last_write: %0d writes, last not at (0,%0d)", got_q.size(), COLS - 1);
    end
    scoreboard_drain("wrap");
    total++;
    if (cursor_row !== 5'd1 || cursor_col !== 7'd0 || top_row !== 5'd0) begin
      bad++;
      $display("FAIL wrap_cursor: cursor=(%0d,%0d) top=%0d required (1,0) 0", cursor_row,
               cursor_col, top_row);
    end
  endtask

  task automatic test_scroll();
    home_screen("scroll_home");
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send("a");
    wait_idle("scroll_setup");
    total++;
    if (cursor_row !== 5'(ROWS - 1) || cursor_col !== 7'd5) begin
      bad++;
      $display("FAIL scroll_setup: cursor=(%0d,%0d) required (%0d,5)", cursor_row, cursor_col,
               ROWS - 1);
    end
    scoreboard_drain("scroll_setup");
    send(8'h0A);
    wait_idle("scroll");
    scoreboard_drain("scroll");
    total++;
    if (top_row !== 5'd1 || cursor_row !== 5'(ROWS - 1)) begin
      bad++;
      $display("FAIL scroll_top: top=%0d row=%0d required 1 %0d", top_row, cursor_row, ROWS - 1);
    end
    send("Z");
    wait_idle("scroll_z");
    total++;
    if (got_q.size() != 1 || got_q[0].row != 0 || got_q[0].col != 5 || got_q[0].ch != 8'h5A) begin
      bad++;
      $display("FAIL scroll_z: %0d writes, first not (0,5,5a)", got_q.size());
    end
    scoreboard_drain("scroll_z");
  endtask

  task automatic test_backspace();
    home_screen("bs_home");
    send(8'h08);
    wait_idle("bs_at_zero");
    total++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd0 || got_q.size() != 0) begin
      bad++;
      $display("FAIL bs_at_zero: cursor=(%0d,%0d) writes=%0d required (0,0) 0", cursor_row,
               cursor_col, got_q.size());
    end
    send("A");
    send("B");
    wait_idle("bs_ab");
    total++;
    if (cursor_col !== 7'd2) begin
      bad++;
      $display("FAIL bs_ab_col: got %0d required 2", cursor_col);
    end
    send(8'h08);
    wait_idle("bs_dec");
    total++;
    if (cursor_col !== 7'd1) begin
      bad++;
      $display("FAIL bs_dec_col: got %0d required 1", cursor_col);
    end
    send(8'h0D);
    wait_idle("bs_cr");
    total++;
    if (cursor_col !== 7'd0 || got_q.size() != 2) begin
      bad++;
      $display("FAIL bs_cr: col=%0d writes=%0d required 0 2", cursor_col, got_q.size());
    end
    scoreboard_drain("bs");
  endtask

  task automatic test_discard();
    logic [7:0] codes [4];
    logic [4:0] r0;
    logic [6:0] c0;
    codes = '{8'h00, 8'h7F, 8'hFF, 8'h1B};
    send("q");
    wait_idle("discard_setup");
    scoreboard_drain("discard_setup");
    r0 = cursor_row;
    c0 = cursor_col;
    for (int i = 0; i < 4; i++) send(codes[i]);
    wait_idle("discard");
    total++;
    if (cursor_row !== r0 || cursor_col !== c0 || got_q.size() != 0 ||
        cursor_col !== 7'(m_col)) begin
      bad++;
      $display("FAIL discard: cursor=(%0d,%0d) writes=%0d required (%0d,%0d) 0", cursor_row,
               cursor_col, got_q.size(), r0, c0);
    end
    scoreboard_drain("discard");
  endtask

  task automatic test_reset_mid_scroll();
    int n;
    home_screen("mid_home");
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    wait_idle("mid_setup");
    scoreboard_drain("mid_setup");
    send(8'h0A);
    n = 0;
    while (got_q.size() < 40 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (got_q.size() != 40) begin
      bad++;
      $display("FAIL mid_abort_writes: got %0d required 40", got_q.size());
    end
    total++;
    if (top_row !== 5'd0 || in_ready !== 1'b0 || write_ce !== 1'b0) begin
      bad++;
      $display("FAIL mid_abort_state: top=%0d rdy=%b ce=%b required 0 0 0", top_row, in_ready,
               write_ce);
    end
    while (exp_q.size() > 40) void'(exp_q.pop_back());
    scoreboard_drain("mid_partial");
    model_clear();
    reset = 1'b0;
    wait_idle("mid_clear");
    scoreboard_drain("mid_clear");
    total++;
    if (top_row !== 5'd0 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
      bad++;
      $display("FAIL mid_after_clear: top=%0d cursor=(%0d,%0d) required 0 (0,0)", top_row,
               cursor_row, cursor_col);
    end
  endtask

  task automatic test_random();
    int ff_used;
    int r;
    logic [7:0] ch;
    logic [7:0] others [12];
    others = '{8'h00, 8'h01, 8'h07, 8'h09, 8'h0B, 8'h0E, 8'h1B, 8'h1F, 8'h7F, 8'h80, 8'hC8,
               8'hFF};
    ff_used = 0;
    for (int i = 0; i < 500; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 60) ch = 8'($urandom_range(32, 126));
      else if (r < 70) ch = 8'h0A;
      else if (r < 78) ch = 8'h0D;
      else if (r < 86) ch = 8'h08;
      else if (r < 98) ch = others[$urandom_range(0, 11)];
      else if (ff_used < 2) begin
        ch = 8'h0C;
        ff_used++;
      end else ch = 8'($urandom_range(32, 126));
      send(ch);
      if (i % 50 == 49) begin
        wait_idle("random");
        total++;
        if (cursor_row !== 5'(m_row) || cursor_col !== 7'(m_col) || top_row !== 5'(m_top)) begin
          bad++;
          $display("FAIL random_pos[%0d]: cursor=(%0d,%0d) top=%0d required (%0d,%0d) %0d", i,
                   cursor_row, cursor_col, top_row, m_row, m_col, m_top);
        end
        scoreboard_drain("random");
      end
    end
  endtask

  initial begin
    m_row = 0;
    m_col = 0;
    m_top = 0;
    test_reset();
    test_back_to_back();
    test_line_wrap();
    test_scroll();
    test_backspace();
    test_discard();
    test_reset_mid_scroll();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
